// File: rtl/pipelined_cla_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_addsub_pkg
// Brief    : Shared opcode constants and flag helper for the pipelined
//            carry-lookahead adder/subtractor and ALU decode.
// Revision : 1.0 - initial release
// ============================================================================
package pipelined_cla_addsub_pkg;

  // ALU decode drives op_sub with one of these
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's-complement overflow: carry into the MSB disagrees with carry out of it
  function automatic logic signed_overflow(input logic cin_msb, input logic cout_msb);
    return cin_msb ^ cout_msb;
  endfunction

endpackage : pipelined_cla_addsub_pkg
`default_nettype wire

// File: rtl/pipelined_cla_addsub_cla_group.sv
`default_nettype none
// ============================================================================
// Module   : cla_group
// Brief    : One combinational carry-lookahead group. Operand b arrives
//            already inverted for subtraction. Every internal carry is built
//            in flat sum-of-products form from g/p and the group carry-in,
//            so the group depth does not grow with a ripple chain.
// Revision : 1.0 - initial release
// ============================================================================
module cla_group #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_cin,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;
  logic [BLOCK:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Expand c[i+1] = g[i] | p[i]&c[i] into independent product terms per bit
  always_comb begin
    logic v_term;
    v_term = 1'b0;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < BLOCK; i++) begin
      // carry-in propagated through every bit 0..i
      v_term = i_cin;
      for (int m = 0; m <= i; m++) begin
        v_term = v_term & w_p[m];
      end
      w_c[i+1] = v_term;
      // carry generated at bit j and propagated through bits j+1..i
      for (int j = 0; j <= i; j++) begin
        v_term = w_g[j];
        for (int m = j + 1; m <= i; m++) begin
          v_term = v_term & w_p[m];
        end
        w_c[i+1] = w_c[i+1] | v_term;
      end
    end
  end

  assign o_sum   = w_p ^ w_c[BLOCK-1:0];
  assign o_cout  = w_c[BLOCK];
  assign o_c_msb = w_c[BLOCK-1];

endmodule : cla_group
`default_nettype wire

// File: rtl/pipelined_cla_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_addsub
// Brief    : Pipelined carry-lookahead adder/subtractor. One BLOCK-bit group
//            resolves per stage; the group carry is registered into the next
//            stage. Unprocessed operand groups travel skewed alongside and
//            finished sum groups are carried forward. The final stage
//            registers the result with carry, overflow and compare flags.
//            All stages share a single advance enable (global stall).
//            WIDTH must be a multiple of BLOCK.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_cla_addsub
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             carry_out,
  output logic             overflow,
  output logic             isNotEqual,
  output logic             isLessThan
);

  localparam int NUM_BLOCKS = WIDTH / BLOCK;

  // Global advance: every stage moves together or none does
  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;

  // Final-stage registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_not_equal;
  logic             r_less_than;

  assign w_advance = out_ready || !r_out_valid;
  assign in_ready  = w_advance;

  // Subtraction is A + ~B + 1; the +1 enters as the stage-0 carry-in
  assign w_b_eff = (op_sub == OP_SUB) ? ~data_operandB : data_operandB;

  generate
    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_stage
      // Operand bits still to be added when this stage sees them, own group included
      localparam int REM_W = (NUM_BLOCKS - k) * BLOCK;

      logic [REM_W-1:0] w_a_src;
      logic [REM_W-1:0] w_b_src;
      logic             w_cin;
      logic             w_vin;

      if (k == 0) begin : g_src_in
        assign w_a_src = data_operandA;
        assign w_b_src = w_b_eff;
        assign w_cin   = op_sub;
        assign w_vin   = in_valid;
      end else begin : g_src_prev
        assign w_a_src = g_stage[k-1].g_mid.r_a_rem;
        assign w_b_src = g_stage[k-1].g_mid.r_b_rem;
        assign w_cin   = g_stage[k-1].g_mid.r_carry;
        assign w_vin   = g_stage[k-1].g_mid.r_valid;
      end

      if (k < NUM_BLOCKS - 1) begin : g_mid
        logic [BLOCK-1:0]         w_sum;
        logic                     w_cout;
        // Carry into the group MSB matters only for the top group
        logic                     w_unused_c_msb;
        logic [(k+1)*BLOCK-1:0]   w_done_next;

        logic                     r_valid;
        logic [REM_W-BLOCK-1:0]   r_a_rem;
        logic [REM_W-BLOCK-1:0]   r_b_rem;
        logic [(k+1)*BLOCK-1:0]   r_sum_done;
        logic                     r_carry;

        cla_group #(
          .BLOCK (BLOCK)
        ) u_group (
          .i_a     (w_a_src[BLOCK-1:0]),
          .i_b     (w_b_src[BLOCK-1:0]),
          .i_cin   (w_cin),
          .o_sum   (w_sum),
          .o_cout  (w_cout),
          .o_c_msb (w_unused_c_msb)
        );

        if (k == 0) begin : g_done_first
          assign w_done_next = w_sum;
        end else begin : g_done_chain
          assign w_done_next = {w_sum, g_stage[k-1].g_mid.r_sum_done};
        end

        // Hold this slot: valid, skewed operands, finished sum groups, group carry
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            r_valid    <= 1'b0;
            r_a_rem    <= '0;
            r_b_rem    <= '0;
            r_sum_done <= '0;
            r_carry    <= 1'b0;
          end else if (w_advance) begin
            r_valid    <= w_vin;
            r_a_rem    <= w_a_src[REM_W-1:BLOCK];
            r_b_rem    <= w_b_src[REM_W-1:BLOCK];
            r_sum_done <= w_done_next;
            r_carry    <= w_cout;
          end
        end
      end else begin : g_last
        logic [BLOCK-1:0] w_sum;
        logic             w_cout;
        logic             w_c_msb;
        logic [WIDTH-1:0] w_result;
        logic             w_ovf;

        cla_group #(
          .BLOCK (BLOCK)
        ) u_group (
          .i_a     (w_a_src),
          .i_b     (w_b_src),
          .i_cin   (w_cin),
          .o_sum   (w_sum),
          .o_cout  (w_cout),
          .o_c_msb (w_c_msb)
        );

        if (k == 0) begin : g_result_single
          assign w_result = w_sum;
        end else begin : g_result_chain
          assign w_result = {w_sum, g_stage[k-1].g_mid.r_sum_done};
        end

        assign w_ovf = signed_overflow(w_c_msb, w_cout);

        // Register the completed result and the flags derived from the top group
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_not_equal <= 1'b0;
            r_less_than <= 1'b0;
          end else if (w_advance) begin
            r_out_valid <= w_vin;
            r_result    <= w_result;
            r_carry_out <= w_cout;
            r_overflow  <= w_ovf;
            r_not_equal <= |w_result;
            r_less_than <= w_result[WIDTH-1] ^ w_ovf;
          end
        end
      end
    end
  endgenerate

  assign out_valid   = r_out_valid;
  assign data_result = r_result;
  assign carry_out   = r_carry_out;
  assign overflow    = r_overflow;
  assign isNotEqual  = r_not_equal;
  assign isLessThan  = r_less_than;

endmodule : pipelined_cla_addsub
`default_nettype wire
